// File: rtl/dma_load_pkg.sv
// rtl/dma_load_pkg.sv - shared command codes, FSM states and error bit indices
package dma_load_pkg;

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_PARAM = 2'd1;
  localparam logic [1:0] CMD_IMAGE = 2'd2;
  localparam logic [1:0] CMD_ACCEL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PARAM,
    S_IMAGE,
    S_RUN,
    S_WAIT,
    S_DONE
  } state_t;

  localparam int ERR_SHORT = 0;
  localparam int ERR_LONG  = 1;

endpackage

// File: rtl/stream_buf_writer.sv
// rtl/stream_buf_writer.sv - turns accepted stream beats into registered buffer writes
// and flags transfers that end short of, or run past, the buffer depth
module stream_buf_writer
  import dma_load_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_active,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_tdata,
  input  logic              i_tvalid,
  input  logic              i_tlast,
  output logic              o_final,
  output logic              o_we,
  output logic [AW-1:0]     o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic [1:0]        o_err
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [AW-1:0]     r_cnt;
  logic              r_we;
  logic [AW-1:0]     r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_err;

  logic w_beat;
  logic w_at_last;

  assign w_beat    = i_active & i_tvalid;
  assign w_at_last = (r_cnt == LAST_ADDR);
  assign o_final   = w_beat & (w_at_last | i_tlast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= '0;
    end else begin
      r_we <= w_beat;
      if (w_beat) begin
        r_addr  <= r_cnt;
        r_wdata <= i_tdata;
      end
      // Holding on the final beat keeps the counter from wrapping past DEPTH-1.
      if (i_clear || i_abort) begin
        r_cnt <= '0;
      end else if (w_beat && !o_final) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (i_clear) begin
        r_err <= '0;
      end else if (o_final) begin
        if (i_tlast && !w_at_last) r_err[ERR_SHORT] <= 1'b1;
        if (w_at_last && !i_tlast) r_err[ERR_LONG]  <= 1'b1;
      end
    end
  end

  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
  assign o_err   = r_err;

endmodule

// File: rtl/dma_load_fsm.sv
// rtl/dma_load_fsm.sv - executes PARAM_LOAD / IMAGE_LOAD / START_ACCEL commands
// and returns a one-cycle completion pulse to the control block
module dma_load_fsm
  import dma_load_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PARAM_DEPTH = 64,
  parameter int PARAM_AW    = 6,
  parameter int IMAGE_DEPTH = 1024,
  parameter int IMAGE_AW    = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          i_state,
  output logic                o_state_cnvt,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  output logic                o_param_we,
  output logic [PARAM_AW-1:0] o_param_addr,
  output logic [DATA_W-1:0]   o_param_wdata,
  output logic                o_img_we,
  output logic [IMAGE_AW-1:0] o_img_addr,
  output logic [DATA_W-1:0]   o_img_wdata,
  output logic                o_accel_start,
  input  logic                i_accel_done,
  output logic                o_busy,
  output logic [1:0]          o_err
);

  state_t r_state;
  state_t w_next;
  logic   r_cnvt;

  logic       w_cmd_idle;
  logic       w_clear;
  logic       w_abort;
  logic       w_param_final;
  logic       w_img_final;
  logic [1:0] w_param_err;
  logic [1:0] w_img_err;

  assign w_cmd_idle = (i_state == CMD_IDLE);
  assign w_clear    = (r_state == S_IDLE) && ((i_state == CMD_PARAM) || (i_state == CMD_IMAGE));
  assign w_abort    = w_cmd_idle &&
                      ((r_state == S_PARAM) || (r_state == S_IMAGE) || (r_state == S_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnvt  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnvt  <= (w_next == S_DONE) && (r_state != S_DONE);
    end
  end

  always_comb begin
    w_next        = r_state;
    s_axis_tready = 1'b0;
    o_accel_start = 1'b0;
    o_busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        case (i_state)
          CMD_PARAM: w_next = S_PARAM;
          CMD_IMAGE: w_next = S_IMAGE;
          CMD_ACCEL: w_next = S_RUN;
          default:   w_next = S_IDLE;
        endcase
      end
      S_PARAM: begin
        s_axis_tready = 1'b1;
        if (w_cmd_idle)         w_next = S_IDLE;
        else if (w_param_final) w_next = S_DONE;
      end
      S_IMAGE: begin
        s_axis_tready = 1'b1;
        if (w_cmd_idle)       w_next = S_IDLE;
        else if (w_img_final) w_next = S_DONE;
      end
      S_RUN: begin
        o_accel_start = 1'b1;
        w_next        = S_WAIT;
      end
      S_WAIT: begin
        if (w_cmd_idle)        w_next = S_IDLE;
        else if (i_accel_done) w_next = S_DONE;
      end
      // Stay parked until the control block drops the command, so a stale
      // command cannot retrigger the same operation.
      S_DONE: begin
        if (w_cmd_idle) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  stream_buf_writer #(
    .DATA_W (DATA_W),
    .DEPTH  (PARAM_DEPTH),
    .AW     (PARAM_AW)
  ) u_param_writer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_active (r_state == S_PARAM),
    .i_abort  (w_abort),
    .i_tdata  (s_axis_tdata),
    .i_tvalid (s_axis_tvalid),
    .i_tlast  (s_axis_tlast),
    .o_final  (w_param_final),
    .o_we     (o_param_we),
    .o_addr   (o_param_addr),
    .o_wdata  (o_param_wdata),
    .o_err    (w_param_err)
  );

  stream_buf_writer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMAGE_DEPTH),
    .AW     (IMAGE_AW)
  ) u_img_writer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_active (r_state == S_IMAGE),
    .i_abort  (w_abort),
    .i_tdata  (s_axis_tdata),
    .i_tvalid (s_axis_tvalid),
    .i_tlast  (s_axis_tlast),
    .o_final  (w_img_final),
    .o_we     (o_img_we),
    .o_addr   (o_img_addr),
    .o_wdata  (o_img_wdata),
    .o_err    (w_img_err)
  );

  assign o_state_cnvt = r_cnvt;
  assign o_err        = w_param_err | w_img_err;

endmodule

// File: tb/tb_dma_load_fsm.sv
// tb/tb_dma_load_fsm.sv - directed/random bench for dma_load_fsm with a transfer-level model
module tb_dma_load_fsm;

  logic        clk;
  logic        rst;
  logic [1:0]  i_state;
  logic        o_state_cnvt;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        o_param_we;
  logic [5:0]  o_param_addr;
  logic [31:0] o_param_wdata;
  logic        o_img_we;
  logic [9:0]  o_img_addr;
  logic [31:0] o_img_wdata;
  logic        o_accel_start;
  logic        i_accel_done;
  logic        o_busy;
  logic [1:0]  o_err;

  int n_assert = 0;
  int n_fail   = 0;
  int n_cnvt   = 0;
  int n_start  = 0;

  // Each write is recorded as {is_image_port, addr[9:0], data[31:0]}.
  logic [42:0] got_q[$];
  logic [42:0] exp_q[$];
  logic [1:0]  exp_err;
  bit          term;

  dma_load_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .i_state       (i_state),
    .o_state_cnvt  (o_state_cnvt),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .o_param_we    (o_param_we),
    .o_param_addr  (o_param_addr),
    .o_param_wdata (o_param_wdata),
    .o_img_we      (o_img_we),
    .o_img_addr    (o_img_addr),
    .o_img_wdata   (o_img_wdata),
    .o_accel_start (o_accel_start),
    .i_accel_done  (i_accel_done),
    .o_busy        (o_busy),
    .o_err         (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_param_we)    got_q.push_back({1'b0, 4'd0, o_param_addr, o_param_wdata});
    if (o_img_we)      got_q.push_back({1'b1, o_img_addr, o_img_wdata});
    if (o_state_cnvt)  n_cnvt++;
    if (o_accel_start) n_start++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tready"}, s_axis_tready, 0);
    chk({tag, "_cnvt"},   o_state_cnvt,  0);
    chk({tag, "_pwe"},    o_param_we,    0);
    chk({tag, "_paddr"},  o_param_addr,  0);
    chk({tag, "_pdata"},  o_param_wdata, 0);
    chk({tag, "_iwe"},    o_img_we,      0);
    chk({tag, "_iaddr"},  o_img_addr,    0);
    chk({tag, "_idata"},  o_img_wdata,   0);
    chk({tag, "_start"},  o_accel_start, 0);
    chk({tag, "_busy"},   o_busy,        0);
    chk({tag, "_err"},    o_err,         0);
  endtask

  task automatic start_load(input logic [1:0] cmd);
    got_q.delete();
    exp_q.delete();
    exp_err = 2'b00;
    term    = 1'b0;
    i_state = cmd;
    @(negedge clk);
  endtask

  // Transfer-level model: a load takes beats in order until the first tlast or
  // until the buffer is full, whichever comes first; later beats are refused.
  task automatic send_beats(input bit is_img, input int depth, input int n, input int tlast_at,
                            input bit gaps, input bit rand_data);
    logic [31:0] d;
    logic [9:0]  a;
    int          g;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        s_axis_tvalid = 1'b0;
        g = $urandom_range(0, 2);
        repeat (g) @(negedge clk);
      end
      d = rand_data ? 32'($urandom) : 32'(k);
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (k == tlast_at);
      chk("tready", s_axis_tready, !term);
      if (!term) begin
        a = 10'(k);
        exp_q.push_back({is_img, a, d});
        if ((k == tlast_at) && (k < depth - 1)) exp_err[0] = 1'b1;
        if ((k == depth - 1) && (k != tlast_at)) exp_err[1] = 1'b1;
        if ((k == tlast_at) || (k == depth - 1)) term = 1'b1;
      end
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    repeat (2) @(negedge clk);
    chk({tag, "_nwrites"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_write"}, got_q[i], exp_q[i]);
  endtask

  task automatic end_cmd(input string tag);
    i_state = 2'd0;
    @(negedge clk);
    chk({tag, "_idle_busy"},   o_busy,        0);
    chk({tag, "_idle_tready"}, s_axis_tready, 0);
  endtask

  int c0;
  int s0;
  logic [31:0] d_last;
  logic [9:0]  a_last;

  initial begin
    rst           = 1'b1;
    i_state       = 2'd0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    i_accel_done  = 1'b0;
    term          = 1'b0;
    exp_err       = 2'b00;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("idle");

    // 1: full parameter load, data equals index, tlast on the final word
    c0 = n_cnvt;
    start_load(2'd1);
    send_beats(1'b0, 64, 64, 63, 1'b0, 1'b0);
    check_writes("t1");
    chk("t1_cnvt_count", n_cnvt - c0, 1);
    chk("t1_err", o_err, exp_err);
    chk("t1_busy_hold", o_busy, 1);
    end_cmd("t1");

    // 2: full image load with random gaps and data
    c0 = n_cnvt;
    start_load(2'd2);
    send_beats(1'b1, 1024, 1024, 1023, 1'b1, 1'b1);
    chk("t2_tready_after_final", s_axis_tready, 0);
    check_writes("t2");
    chk("t2_cnvt_count", n_cnvt - c0, 1);
    chk("t2_err", o_err, exp_err);
    end_cmd("t2");

    // 3: short transfer, tlast on beat 9
    c0 = n_cnvt;
    start_load(2'd1);
    send_beats(1'b0, 64, 10, 9, 1'b1, 1'b1);
    check_writes("t3");
    chk("t3_cnvt_count", n_cnvt - c0, 1);
    chk("t3_err", o_err, exp_err);
    chk("t3_err_short", o_err, 2'b01);
    end_cmd("t3");

    // 4: long transfer, no tlast, 65th beat must be refused
    c0 = n_cnvt;
    start_load(2'd1);
    chk("t4_err_cleared", o_err, 0);
    send_beats(1'b0, 64, 65, -1, 1'b0, 1'b1);
    check_writes("t4");
    chk("t4_cnvt_count", n_cnvt - c0, 1);
    chk("t4_err", o_err, exp_err);
    chk("t4_err_long", o_err, 2'b10);
    end_cmd("t4");

    // 5: accelerator run, done held during the start cycle must be ignored
    c0 = n_cnvt;
    s0 = n_start;
    i_state      = 2'd3;
    i_accel_done = 1'b1;
    @(negedge clk);
    chk("t5_start_pulse", o_accel_start, 1);
    @(negedge clk);
    chk("t5_start_drop", o_accel_start, 0);
    chk("t5_busy_wait", o_busy, 1);
    i_accel_done = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_no_early_cnvt", n_cnvt - c0, 0);
    i_accel_done = 1'b1;
    @(negedge clk);
    i_accel_done = 1'b0;
    chk("t5_cnvt_after_done", o_state_cnvt, 1);
    repeat (10) @(negedge clk);
    chk("t5_one_start", n_start - s0, 1);
    chk("t5_one_cnvt", n_cnvt - c0, 1);
    chk("t5_busy_hold", o_busy, 1);
    end_cmd("t5");

    // 6a: abort an image load after 100 beats
    c0 = n_cnvt;
    start_load(2'd2);
    send_beats(1'b1, 1024, 100, -1, 1'b1, 1'b1);
    i_state = 2'd0;
    @(negedge clk);
    chk("t6a_busy", o_busy, 0);
    chk("t6a_tready", s_axis_tready, 0);
    check_writes("t6a");
    chk("t6a_no_cnvt", n_cnvt - c0, 0);
    chk("t6a_err", o_err, 0);

    // final beat and abort in the same cycle: write still lands, no completion
    c0 = n_cnvt;
    start_load(2'd1);
    send_beats(1'b0, 64, 9, -1, 1'b0, 1'b1);
    d_last = 32'($urandom);
    a_last = 10'd9;
    exp_q.push_back({1'b0, a_last, d_last});
    s_axis_tdata  = d_last;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b1;
    i_state       = 2'd0;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    chk("abort_final_busy", o_busy, 0);
    check_writes("abort_final");
    chk("abort_final_no_cnvt", n_cnvt - c0, 0);

    // 6b: second image load restarts at address 0, then reset mid-load
    c0 = n_cnvt;
    start_load(2'd2);
    send_beats(1'b1, 1024, 30, -1, 1'b0, 1'b1);
    chk("t6b_busy", o_busy, 1);
    chk("t6b_we_pending", o_img_we, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    i_state = 2'd0;
    rst     = 1'b0;
    check_writes("t6b");
    chk("t6b_no_cnvt", n_cnvt - c0, 0);
    chk_zero("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_load_fsm.md
Name: dma_load_fsm

Overview:
Executes the command state driven by the AXI-lite control block. It consumes the 2-bit command state and the DMA's AXI-Stream MM2S data. Parameter and image words are written into external BRAM write ports, and the accelerator start/done handshake is sequenced. When a command completes it returns a one-cycle completion pulse, which the control block uses to go back to IDLE.

Parameters:
DATA_W, 32, stream and buffer word width
PARAM_DEPTH, 64, parameter words per PARAM_LOAD
PARAM_AW, 6, parameter buffer address width (clog2 PARAM_DEPTH)
IMAGE_DEPTH, 1024, image words per IMAGE_LOAD
IMAGE_AW, 10, image buffer address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_state  in  2  command from control block: 0 IDLE, 1 PARAM_LOAD, 2 IMAGE_LOAD, 3 START_ACCEL
o_state_cnvt  out  1  one-cycle pulse, command finished
s_axis_tdata  in  DATA_W  DMA stream data
s_axis_tvalid  in  1  stream valid
s_axis_tready  out  1  stream ready
s_axis_tlast  in  1  last beat of DMA transfer
o_param_we  out  1  parameter buffer write enable
o_param_addr  out  PARAM_AW  parameter buffer address
o_param_wdata  out  DATA_W  parameter buffer data
o_img_we  out  1  image buffer write enable
o_img_addr  out  IMAGE_AW  image buffer address
o_img_wdata  out  DATA_W  image buffer data
o_accel_start  out  1  one-cycle accelerator start pulse
i_accel_done  in  1  accelerator done pulse/level
o_busy  out  1  FSM not in S_IDLE
o_err  out  2  sticky: [0] tlast before final word (short), [1] final word without tlast (long)

Behaviour:
- Reset (async, rst=1): FSM=S_IDLE, counter=0, all outputs 0 including o_err.
- FSM states: S_IDLE, S_PARAM, S_IMAGE, S_RUN, S_WAIT, S_DONE.
- S_IDLE:
  - i_state=1 -> S_PARAM; i_state=2 -> S_IMAGE; i_state=3 -> S_RUN; i_state=0 stays.
  - Entering S_PARAM or S_IMAGE clears counter and o_err.
- S_PARAM / S_IMAGE:
  - s_axis_tready=1 (combinational from state).
  - A beat is accepted when tvalid&&tready.
  - Each beat registers we=1, addr=counter, wdata=tdata on the next cycle (1-cycle latency). Writes go to the param or image port per state; we=0 otherwise.
  - Counter increments per beat.
  - Termination, on the accepted beat where counter==DEPTH-1 or tlast=1:
    - tlast with counter<DEPTH-1 sets o_err[0].
    - counter==DEPTH-1 without tlast sets o_err[1].
    - Both at the final word is clean.
    - Transition to S_DONE; tready drops in the next cycle.
  - Counter never wraps; beats beyond DEPTH are not accepted.
- S_RUN:
  - o_accel_start=1 for exactly this one cycle, then -> S_WAIT.
  - i_accel_done is ignored in S_RUN.
- S_WAIT:
  - i_accel_done=1 -> S_DONE.
  - Otherwise wait indefinitely; no timeout.
- S_DONE:
  - o_state_cnvt=1 for exactly one cycle (registered pulse on entry).
  - Then hold until i_state==0, then -> S_IDLE. This prevents re-triggering on the stale command.
  - If i_state is already 0 in the cycle after the pulse, return immediately.
- Abort: i_state==0 observed while in S_PARAM, S_IMAGE or S_WAIT -> S_IDLE next cycle.
  - No cnvt pulse; tready=0; counter cleared.
  - Any write already registered still completes.
- Simultaneous final beat and abort: the abort wins; the beat's write still issues; no cnvt.
- Reset mid-load: everything returns to reset values immediately; buffer contents are undefined.
- o_busy = (state != S_IDLE).

Decomposition:
- Package dma_load_pkg holds:
  - command encodings CMD_IDLE/CMD_PARAM/CMD_IMAGE/CMD_ACCEL, shared with the control block;
  - FSM state localparams;
  - error bit indices.
- One natural sub-module: stream_buf_writer. It holds counter, termination detect, registered we/addr/wdata and error flags, parameterised by DEPTH/AW. It is instantiated twice, for param and image.

Test Plan:
1. i_state=1; stream 64 beats 0..63 with tlast on beat 63 -> param_we pulses 64×; addr k gets data k; one cnvt pulse; o_err=0; idle after i_state=0.
2. i_state=2; 1024 beats with random tvalid gaps; tlast on 1023 -> img writes match beat order exactly; tready=0 after final beat; o_err=0.
3. i_state=1; tlast on beat 9 -> 10 writes (addr 0..9); o_err=2'b01; cnvt pulse.
4. i_state=1; 64 beats with no tlast; 65th beat offered -> 64 writes; o_err=2'b10; 65th beat not accepted (tready=0).
5. i_state=3; hold i_accel_done=1 from start; then deassert; pulse done 20 cycles later -> exactly one start pulse; done in S_RUN ignored; cnvt one cycle after done; no second start while i_state stays 3.
6. i_state=2; drop i_state to 0 after 100 beats; then assert rst mid-load in a second run -> abort to idle, no cnvt, counter 0; reset gives all outputs 0 asynchronously.
